// File: rtl/dataflow_pkg.sv
// Shared types for the dataflow router: routing modes, the default word type
// and the source-lane helper used by the permutation network.
package dataflow_pkg;

  localparam int WORD_W = 20;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    BCAST = 2'd0,
    PASS  = 2'd1,
    ROT   = 2'd2,
    REV   = 2'd3
  } route_mode_e;

  // Source lane feeding output lane 'lane'; out-of-range broadcast selects fall back to lane 0.
  function automatic int routeSrc(route_mode_e mode, int sel, int lane, int lanes);
    int src;
    src = lane;
    case (mode)
      BCAST:   src = (sel < lanes) ? sel : 0;
      PASS:    src = lane;
      ROT:     src = (lane + sel) % lanes;
      REV:     src = lanes - 1 - lane;
      default: src = lane;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/dataflow_router_lane_permute.sv
// Combinational LANE x VEC lane permutation (broadcast, pass, rotate, reverse).
// Words are moved bit-exact; only whole lanes are selected.
module lane_permute import dataflow_pkg::*; #(
  parameter int W    = 20,
  parameter int LANE = 128,
  parameter int VEC  = 16,
  parameter int SW   = $clog2(LANE)
) (
  input  logic [1:0]                      mode_i,
  input  logic [SW-1:0]                   sel_i,
  input  logic [LANE-1:0][VEC-1:0][W-1:0] data_i,
  output logic [LANE-1:0][VEC-1:0][W-1:0] routed_o
);

  always_comb begin
    routed_o = '0;
    for (int i = 0; i < LANE; i++) begin
      routed_o[i] = data_i[SW'(routeSrc(route_mode_e'(mode_i), int'(sel_i), i, LANE))];
    end
  end

endmodule

// File: rtl/dataflow_router.sv
// Two-stage elastic lane router with valid/ready handshaking on both sides.
// Optional DATAFLOW_ROUTER_PERF_EN adds delivered-beat and stall-cycle counters.
module dataflow_router import dataflow_pkg::*; #(
  parameter  int IL   = 8,
  parameter  int FL   = 12,
  parameter  int LANE = 128,
  parameter  int VEC  = 16,
  localparam int W    = IL + FL,
  localparam int SW   = $clog2(LANE)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LANE-1:0][VEC-1:0][W-1:0] in,
  input  logic [1:0]                      in_mode,
  input  logic [SW-1:0]                   in_sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [LANE-1:0][VEC-1:0][W-1:0] out,
  output logic                            out_valid,
  input  logic                            out_ready
`ifdef DATAFLOW_ROUTER_PERF_EN
  ,
  output logic [31:0]                     beat_cnt,
  output logic [31:0]                     stall_cnt
`endif
);

  logic                            s1_valid_q, s1_valid_d;
  logic [LANE-1:0][VEC-1:0][W-1:0] s1_data_q, s1_data_d;
  logic [1:0]                      s1_mode_q, s1_mode_d;
  logic [SW-1:0]                   s1_sel_q, s1_sel_d;
  logic                            s2_valid_q, s2_valid_d;
  logic [LANE-1:0][VEC-1:0][W-1:0] s2_data_q, s2_data_d;
  logic [LANE-1:0][VEC-1:0][W-1:0] routed;
  logic                            adv2;
  logic                            accept;

  lane_permute #(
    .W    (W),
    .LANE (LANE),
    .VEC  (VEC),
    .SW   (SW)
  ) u_permute (
    .mode_i   (s1_mode_q),
    .sel_i    (s1_sel_q),
    .data_i   (s1_data_q),
    .routed_o (routed)
  );

  // Stage 2 drains when empty or when the consumer takes it; stage 1 refills as it empties.
  assign adv2     = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || adv2;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_sel_d   = s1_sel_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in;
      s1_mode_d  = in_mode;
      s1_sel_d   = in_sel;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    if (adv2) begin
      s2_valid_d = 1'b1;
      s2_data_d  = routed;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_sel_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_sel_q   <= s1_sel_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out       = s2_data_q;
  assign out_valid = s2_valid_q;

`ifdef DATAFLOW_ROUTER_PERF_EN
  logic [31:0] beat_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (s2_valid_q && out_ready) beat_cnt_q <= beat_cnt_q + 32'd1;
      if (s2_valid_q && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dataflow_router.sv
// Self-checking bench for dataflow_router: table-driven routing vectors, scoreboard
// ordering, stall/backpressure and mid-operation reset sequences.
module tb_dataflow_router;
  import dataflow_pkg::*;

  localparam int W    = 20;
  localparam int LANE = 128;
  localparam int VEC  = 16;
  localparam int SW   = 7;

  typedef logic [LANE-1:0][VEC-1:0][W-1:0] arr_t;
  typedef logic [VEC-1:0][W-1:0] laneT;

  typedef struct {
    arr_t data;
    bit   hasSpot;
    laneT lane0;
    laneT laneLast;
  } sbEntry_t;

  typedef struct {
    route_mode_e mode;
    int          sel;
    int          kind;
    int          src0;
    int          srcLast;
  } vector_t;

  logic          clk = 1'b0;
  logic          reset;
  arr_t          in;
  arr_t          out;
  logic [1:0]    in_mode;
  logic [SW-1:0] in_sel;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
`ifdef DATAFLOW_ROUTER_PERF_EN
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cnt;
`endif

  int       total = 0;
  int       bad = 0;
  sbEntry_t sbQ[$];
  bit       spotEn = 1'b0;
  int       spotSrc0 = 0;
  int       spotSrcLast = 0;

  dataflow_router dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_mode   (in_mode),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DATAFLOW_ROUTER_PERF_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // kind 0: i*16+k+offset, kind 1: same but lane 5 holds k-8, kind 2: random words
  function automatic arr_t makePattern(int kind, int offset);
    arr_t a;
    for (int i = 0; i < LANE; i++) begin
      for (int k = 0; k < VEC; k++) begin
        if (kind == 2) a[i][k] = W'($urandom);
        else if (kind == 1 && i == 5) a[i][k] = W'(k - 8);
        else a[i][k] = W'(i * 16 + k + offset);
      end
    end
    return a;
  endfunction

  function automatic arr_t routeModel(arr_t a, route_mode_e mode, int sel);
    arr_t r;
    int src;
    logic [SW-1:0] srcIdx;
    for (int i = 0; i < LANE; i++) begin
      if (mode == BCAST) src = (sel >= LANE) ? 0 : sel;
      else if (mode == ROT) begin
        src = i + sel;
        while (src >= LANE) src = src - LANE;
      end
      else if (mode == REV) src = LANE - 1 - i;
      else src = i;
      srcIdx = SW'(src);
      r[i] = a[srcIdx];
    end
    return r;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic checkArray(string name, arr_t act, arr_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < LANE; i++) begin
        if (act[i] !== exp[i]) begin
          for (int k = 0; k < VEC; k++) begin
            if (act[i][k] !== exp[i][k]) begin
              $display("[TB] FAIL %s lane %0d elem %0d got %h want %h", name, i, k, act[i][k], exp[i][k]);
              return;
            end
          end
        end
      end
    end
  endtask

  task automatic checkLane(string name, laneT act, laneT exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int k = 0; k < VEC; k++) begin
        if (act[k] !== exp[k]) begin
          $display("[TB] FAIL %s elem %0d got %h want %h", name, k, act[k], exp[k]);
          return;
        end
      end
    end
  endtask

  task automatic applyStimulus(logic valid, route_mode_e mode, int sel, arr_t data);
    in_valid = valid;
    in_mode  = mode;
    in_sel   = SW'(sel);
    in       = data;
  endtask

  // One clock: handshakes are sampled on the falling edge, returns 1ns after the rising edge
  task automatic step();
    sbEntry_t e;
    logic [SW-1:0] i0, iL;
    @(negedge clk);
    if (reset) begin
      sbQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedDelivery got out_valid=1 want no pending transfer");
        end else begin
          e = sbQ.pop_front();
          checkArray("scoreboard", out, e.data);
          if (e.hasSpot) begin
            checkLane("spotLane0", out[0], e.lane0);
            checkLane("spotLaneLast", out[LANE-1], e.laneLast);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data    = routeModel(in, route_mode_e'(in_mode), int'(in_sel));
        e.hasSpot = spotEn;
        i0        = SW'(spotSrc0);
        iL        = SW'(spotSrcLast);
        e.lane0   = in[i0];
        e.laneLast = in[iL];
        sbQ.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sbQ.size() != 0; n++) step();
    checkOutput("drainEmpty", 64'(sbQ.size()), 64'(0));
    step();
  endtask

  initial begin
    vector_t vecs[11];
    arr_t    patA;
    arr_t    expA;
    int      validCount;

    vecs[0]  = '{PASS,  0,   0, 0,   127};
    vecs[1]  = '{BCAST, 5,   0, 5,   5};
    vecs[2]  = '{ROT,   1,   0, 1,   0};
    vecs[3]  = '{ROT,   127, 0, 127, 126};
    vecs[4]  = '{ROT,   0,   0, 0,   127};
    vecs[5]  = '{REV,   0,   0, 127, 0};
    vecs[6]  = '{BCAST, 127, 0, 127, 127};
    vecs[7]  = '{PASS,  33,  0, 0,   127};
    vecs[8]  = '{BCAST, 5,   1, 5,   5};
    vecs[9]  = '{ROT,   64,  2, 64,  63};
    vecs[10] = '{REV,   9,   2, 127, 0};

    // Reset held with a valid producer: nothing may be captured
    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, PASS, 0, makePattern(0, 0));
    repeat (3) step();
    checkOutput("rstOutValid", 64'(out_valid), 64'(0));
    checkArray("rstOutZero", out, '0);
    checkOutput("rstInReady", 64'(in_ready), 64'(1));
    reset = 1'b0;

    // Ten back-to-back PASS transfers, first one accepted right after reset drops
    validCount = 0;
    spotSrc0 = 0;
    spotSrcLast = LANE - 1;
    for (int t = 0; t < 13; t++) begin
      if (t < 10) applyStimulus(1'b1, PASS, 0, makePattern(0, t * 4096));
      else in_valid = 1'b0;
      spotEn = (t == 0);
      step();
      if (t == 0) checkOutput("latEdge1", 64'(out_valid), 64'(0));
      if (t == 1) checkOutput("latEdge2", 64'(out_valid), 64'(1));
      if (out_valid) validCount++;
    end
    checkOutput("b2bValidCycles", 64'(validCount), 64'(10));
    spotEn = 1'b0;
    drain();

    // Routing table, streamed back to back
    foreach (vecs[n]) begin
      applyStimulus(1'b1, vecs[n].mode, vecs[n].sel, makePattern(vecs[n].kind, 0));
      spotEn = 1'b1;
      spotSrc0 = vecs[n].src0;
      spotSrcLast = vecs[n].srcLast;
      step();
    end
    in_valid = 1'b0;
    spotEn = 1'b0;
    drain();

    // Broadcast of negative words keeps the exact two's-complement bits
    applyStimulus(1'b1, BCAST, 5, makePattern(1, 0));
    step();
    in_valid = 1'b0;
    step();
    checkOutput("bcastNegLane64", 64'(out[64][0]), 64'(20'hFFFF8));
    checkOutput("bcastPosLane3", 64'(out[3][15]), 64'(20'h00007));
    drain();

    // Backpressure: two accepts fill both stages, then five stalled cycles
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    out_ready = 1'b0;
    patA = makePattern(2, 0);
    expA = routeModel(patA, ROT, 3);
    applyStimulus(1'b1, ROT, 3, patA);
    step();
    applyStimulus(1'b1, REV, 0, makePattern(2, 0));
    step();
    applyStimulus(1'b1, PASS, 0, makePattern(2, 0));
    for (int c = 0; c < 5; c++) begin
      checkOutput("stallInReady", 64'(in_ready), 64'(0));
      checkOutput("stallOutValid", 64'(out_valid), 64'(1));
      checkArray("stallHold", out, expA);
      step();
    end
    out_ready = 1'b1;
    step();
    applyStimulus(1'b1, BCAST, 100, makePattern(2, 0));
    step();
    applyStimulus(1'b1, ROT, 77, makePattern(2, 0));
    step();
    in_valid = 1'b0;
    drain();
`ifdef DATAFLOW_ROUTER_PERF_EN
    checkOutput("perfStall", 64'(stall_cnt), 64'(5));
    checkOutput("perfBeat", 64'(beat_cnt), 64'(5));
`endif

    // Reset with both stages full: in-flight transfers must vanish
    out_ready = 1'b0;
    applyStimulus(1'b1, ROT, 9, makePattern(2, 0));
    step();
    applyStimulus(1'b1, REV, 0, makePattern(2, 0));
    step();
    checkOutput("flushPreFull", 64'(in_ready), 64'(0));
    reset = 1'b1;
    step();
    checkOutput("flushOutValid", 64'(out_valid), 64'(0));
    checkOutput("flushInReady", 64'(in_ready), 64'(1));
    checkArray("flushOutZero", out, '0);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("flushNoValid", 64'(out_valid), 64'(0));
    end
`ifdef DATAFLOW_ROUTER_PERF_EN
    checkOutput("perfBeatClr", 64'(beat_cnt), 64'(0));
`endif
    checkOutput("finalQueueEmpty", 64'(sbQ.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
